// File: rtl/cursor_motion_ctrl.sv
// Cursor position/size owner: per-frame keyboard stepping with hold-to-accelerate and edge clamping.
// Define CURSOR_WRAP_EN to jump to the opposite edge instead of clamping.
module cursor_motion_ctrl #(
  parameter int unsigned X_CENTER     = 320,
  parameter int unsigned Y_CENTER     = 240,
  parameter int unsigned X_MAX        = 639,
  parameter int unsigned Y_MAX        = 479,
  parameter int unsigned CURSOR_SIZE  = 4,
  parameter int unsigned MAX_STEP     = 8,
  parameter int unsigned ACCEL_FRAMES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] CursorX,
  output logic [9:0] CursorY,
  output logic [9:0] Cursor_size,
  output logic       select
);

  localparam logic [10:0] MIN_POS = 11'(CURSOR_SIZE);
  localparam logic [10:0] X_LIM   = 11'(X_MAX - CURSOR_SIZE);
  localparam logic [10:0] Y_LIM   = 11'(Y_MAX - CURSOR_SIZE);
  localparam logic [7:0]  KC_UP    = 8'h1A;
  localparam logic [7:0]  KC_DOWN  = 8'h16;
  localparam logic [7:0]  KC_LEFT  = 8'h04;
  localparam logic [7:0]  KC_RIGHT = 8'h07;
  localparam logic [7:0]  KC_SPACE = 8'h2C;

  typedef enum logic {IDLE, MOVING} state_t;
  typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  state_t      state_q, state_d;
  dir_t        prev_dir_q, prev_dir_d;
  dir_t        dir;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [9:0]  step_q, step_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        s1_q, s2_q, s3_q;
  logic [7:0]  kc_prev_q;
  logic        select_q, select_d;
  logic        tick;
  logic        do_move;
  logic [9:0]  move_amt;

  // Positions never exceed the limit, so the low 10 bits of the 11-bit result are exact.
  function automatic logic [9:0] next_pos(input logic [9:0] pos, input logic [9:0] amt,
                                          input logic [10:0] limit, input logic dec);
    logic [10:0] p, a, r;
    p = {1'b0, pos};
    a = {1'b0, amt};
    if (dec) begin
      if (p < MIN_POS + a) begin
`ifdef CURSOR_WRAP_EN
        r = limit;
`else
        r = MIN_POS;
`endif
      end else begin
        r = p - a;
      end
    end else begin
      if (p + a > limit) begin
`ifdef CURSOR_WRAP_EN
        r = MIN_POS;
`else
        r = limit;
`endif
      end else begin
        r = p + a;
      end
    end
    return r[9:0];
  endfunction

  assign tick = s2_q & ~s3_q;

  always_comb begin
    dir = DIR_NONE;
    case (keycode)
      KC_UP:    dir = DIR_UP;
      KC_DOWN:  dir = DIR_DOWN;
      KC_LEFT:  dir = DIR_LEFT;
      KC_RIGHT: dir = DIR_RIGHT;
      default:  dir = DIR_NONE;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    prev_dir_d = prev_dir_q;
    step_d     = step_q;
    hold_cnt_d = hold_cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    do_move    = 1'b0;
    move_amt   = 10'd0;

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (dir != DIR_NONE) begin
            state_d    = MOVING;
            do_move    = 1'b1;
            move_amt   = 10'd1;
            step_d     = 10'd1;
            hold_cnt_d = 16'd1;
            prev_dir_d = dir;
          end
        end
        MOVING: begin
          if (dir == DIR_NONE) begin
            state_d    = IDLE;
            step_d     = 10'd1;
            hold_cnt_d = 16'd0;
            prev_dir_d = DIR_NONE;
          end else if (dir == prev_dir_q) begin
            do_move  = 1'b1;
            move_amt = step_q;
            // The step bump takes effect on the following tick, not this one.
            if (hold_cnt_q + 16'd1 >= 16'(ACCEL_FRAMES)) begin
              hold_cnt_d = 16'd0;
              step_d     = (step_q >= 10'(MAX_STEP)) ? 10'(MAX_STEP) : step_q + 10'd1;
            end else begin
              hold_cnt_d = hold_cnt_q + 16'd1;
            end
          end else begin
            do_move    = 1'b1;
            move_amt   = 10'd1;
            step_d     = 10'd1;
            hold_cnt_d = 16'd1;
            prev_dir_d = dir;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (do_move) begin
      case (dir)
        DIR_UP:    y_d = next_pos(y_q, move_amt, Y_LIM, 1'b1);
        DIR_DOWN:  y_d = next_pos(y_q, move_amt, Y_LIM, 1'b0);
        DIR_LEFT:  x_d = next_pos(x_q, move_amt, X_LIM, 1'b1);
        DIR_RIGHT: x_d = next_pos(x_q, move_amt, X_LIM, 1'b0);
        default:   ;
      endcase
    end
  end

  always_comb begin
    select_d = (keycode == KC_SPACE) && (kc_prev_q != KC_SPACE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      state_q    <= IDLE;
      prev_dir_q <= DIR_NONE;
      step_q     <= 10'd1;
      hold_cnt_q <= 16'd0;
      x_q        <= 10'(X_CENTER);
      y_q        <= 10'(Y_CENTER);
      kc_prev_q  <= 8'h00;
      select_q   <= 1'b0;
    end else begin
      s1_q       <= frame_clk;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      state_q    <= state_d;
      prev_dir_q <= prev_dir_d;
      step_q     <= step_d;
      hold_cnt_q <= hold_cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      kc_prev_q  <= keycode;
      select_q   <= select_d;
    end
  end

  assign CursorX     = x_q;
  assign CursorY     = y_q;
  assign Cursor_size = 10'(CURSOR_SIZE);
  assign select      = select_q;

endmodule

// File: doc/cursor_motion_ctrl.md
Name: cursor_motion_ctrl

Overview:
- Upstream neighbour of the cursor colour mapper: owns the on-screen cursor position and size, which the mapper draws as a diamond.
- Consumes the current USB keyboard keycode and the VGA frame clock (vsync); updates position once per frame with hold-to-accelerate stepping and edge clamping.
- Also emits a one-cycle select pulse for the game logic.

Parameters:
- X_CENTER, 320, reset X position.
- Y_CENTER, 240, reset Y position.
- X_MAX, 639, last visible column.
- Y_MAX, 479, last visible row.
- CURSOR_SIZE, 4, half-diagonal driven on Cursor_size; also the edge margin.
- MAX_STEP, 8, saturation value of the per-frame step, in pixels.
- ACCEL_FRAMES, 4, consecutive held frames per step increment (must be ≥1).

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  asynchronous, active-low reset.
- frame_clk  in  1  vsync-rate frame clock, asynchronous to Clk.
- keycode  in  8  currently held USB HID keycode; 0x00 = none.
- CursorX  out  10  cursor centre column.
- CursorY  out  10  cursor centre row.
- Cursor_size  out  10  constant CURSOR_SIZE.
- select  out  1  one-Clk pulse on space press.

Behaviour:
- Reset (Reset=0, async):
  - CursorX=X_CENTER, CursorY=Y_CENTER.
  - step=1, hold_cnt=0, prev_dir=NONE, state=IDLE, select=0.
  - All three synchroniser flops=0.
- Frame tick:
  - frame_clk passes through 2-flop synchroniser s1→s2, then edge flop s3; tick = s2 & ~s3.
  - Position registers update on the Clk edge where tick=1, i.e. the 3rd Clk edge after frame_clk is first sampled high.
  - Exactly one tick per frame_clk rising edge, regardless of high time.
- Direction decode:
  - 0x1A=UP (Y−), 0x16=DOWN (Y+), 0x04=LEFT (X−), 0x07=RIGHT (X+).
  - Any other code = NONE.
  - One axis per frame; no diagonal.
- FSM, evaluated only on tick:
  - IDLE: dir=NONE → stay; no move. dir≠NONE → MOVING; move by 1; step=1; hold_cnt=1; prev_dir=dir.
  - MOVING, dir==prev_dir:
    - Move by current step, then hold_cnt++.
    - When hold_cnt reaches ACCEL_FRAMES: hold_cnt=0 and step=min(step+1, MAX_STEP). The new step applies from the next tick.
  - MOVING, dir≠prev_dir and dir≠NONE: treated as a fresh press (move by 1, step=1, hold_cnt=1, prev_dir=dir); stay MOVING.
  - MOVING, dir=NONE → IDLE; step=1, hold_cnt=0, prev_dir=NONE; no move.
- Step sequence for ACCEL_FRAMES=4: 1,1,1,1,2,2,2,2,3,… saturating at MAX_STEP.
- Clamp, with MIN=CURSOR_SIZE and limits X_MAX−CURSOR_SIZE / Y_MAX−CURSOR_SIZE:
  - Decrement: if pos < MIN+step, pos=MIN; else pos−step.
  - Increment: if pos+step > limit, pos=limit; else pos+step.
  - All compares use 11-bit unsigned so pos+step never overflows.
  - Step and FSM still advance while pinned at an edge.
- Select:
  - Evaluated every Clk, independent of tick.
  - select=1 for one Clk when keycode==0x2C and the previous-cycle keycode≠0x2C.
  - Holding space gives no repeats.
  - Space decodes as NONE for motion.
- Cursor_size: constant assign, no register.
- Reset mid-frame or mid-acceleration: immediate return to reset values. A tick pending in the synchroniser is discarded.

Optional Feature:
- Macro: CURSOR_WRAP_EN.
- Defined:
  - A move that would cross the lower limit places pos at the upper limit.
  - A move that would cross the upper limit places pos at MIN.
  - Exact jump to the opposite edge; no modular remainder.
- Undefined: clamp behaviour as above.
- Step/FSM logic is identical in both builds.

Test Plan:
- Reset → CursorX=320, CursorY=240, Cursor_size=4, select=0. Keycode=0x00 for 5 frames → no change.
- keycode=0x07 for 1 frame, then 0x00 → CursorX=321. Update appears exactly 3 Clk edges after frame_clk sampled high. frame_clk held high 1000 Clk → only one update.
- keycode=0x07 held 12 frames → steps 1×4, 2×4, 3×4; CursorX=344. Switch to 0x04 next frame → CursorX=343 (step reset to 1).
- Start X=6, hold 0x04 → 5, 4, 4, 4. Start Y=473, hold 0x16 → 474, 475, 475. With CURSOR_WRAP_EN: X=4 plus LEFT → 635.
- keycode 0x00→0x2C held 20 Clk → select high exactly 1 Clk. Release and repress → second single pulse. No cursor movement.
- Hold 0x07 for 6 frames (step=2), assert Reset mid-frame for 2 Clk, release → position 320/240. Next frame with 0x07 held moves by 1.
